// File: rtl/lmsm_sequencer_if.sv
// Handshake bundle between an LM/SM requester and the sequencer, memory
// response and register-file control included.
interface lmsm_sequencer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned NREG   = 8
);
  localparam int unsigned IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned CNT_W = $clog2(NREG + 1);

  logic              start;
  logic              is_store;
  logic [ADDR_W-1:0] base_addr;
  logic [NREG-1:0]   reg_mask;
  logic              mem_ready;
  logic              busy;
  logic              done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [IDX_W-1:0]  rf_sel;
  logic              rf_wen;
  logic [CNT_W-1:0]  xfer_count;

  // Requester side: issues operations and answers memory accesses
  modport master (
    output start, is_store, base_addr, reg_mask, mem_ready,
    input  busy, done, mem_req, mem_we, mem_addr, rf_sel, rf_wen, xfer_count
  );

  // Sequencer side
  modport slave (
    input  start, is_store, base_addr, reg_mask, mem_ready,
    output busy, done, mem_req, mem_we, mem_addr, rf_sel, rf_wen, xfer_count
  );
endinterface

// File: rtl/lmsm_sequencer.sv
// Load-multiple / store-multiple sequencer: walks the register mask in
// ascending order, issuing one memory access per set bit at consecutive
// addresses starting from the base address.
module lmsm_sequencer #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned NREG   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  lmsm_sequencer_if.slave    bus_if
);
  localparam int unsigned IDX_W = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int unsigned CNT_W = $clog2(NREG + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e             state_q;
  logic               store_q;
  logic [ADDR_W-1:0]  cur_addr_q;
  logic [NREG-1:0]    rem_mask_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CNT_W-1:0]   xfer_count_q;
  logic               busy_q;
  logic               done_q;
  logic               mem_req_q;
  logic               mem_we_q;

  logic [IDX_W-1:0]   idx_d;
  logic [ADDR_W-1:0]  cur_addr_d;
  logic [CNT_W-1:0]   xfer_count_d;

  // Index of the lowest set bit; scanning downward lets the lowest win
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NREG-1:0] m);
    lowest_set = '0;
    for (int i = int'(NREG) - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  // Next values for the datapath registers
  assign idx_d        = lowest_set(rem_mask_q);
  assign cur_addr_d   = cur_addr_q + ADDR_W'(1);
  assign xfer_count_d = xfer_count_q + CNT_W'(1);

  // Sequencer FSM with registered outputs decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      store_q      <= 1'b0;
      cur_addr_q   <= '0;
      rem_mask_q   <= '0;
      idx_q        <= '0;
      xfer_count_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus_if.start) begin
            store_q      <= bus_if.is_store;
            cur_addr_q   <= bus_if.base_addr;
            rem_mask_q   <= bus_if.reg_mask;
            xfer_count_q <= '0;
            busy_q       <= 1'b1;
            state_q      <= SCAN;
          end
        end
        SCAN: begin
          if (rem_mask_q == '0) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q     <= idx_d;
            mem_req_q <= 1'b1;
            mem_we_q  <= store_q;
            state_q   <= ACCESS;
          end
        end
        ACCESS: begin
          // Outputs stay put until memory accepts the access
          if (bus_if.mem_ready) begin
            rem_mask_q[idx_q] <= 1'b0;
            cur_addr_q        <= cur_addr_d;
            xfer_count_q      <= xfer_count_d;
            mem_req_q         <= 1'b0;
            mem_we_q          <= 1'b0;
            state_q           <= SCAN;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Output mapping; the load write strobe follows mem_ready in the same cycle
  assign bus_if.busy       = busy_q;
  assign bus_if.done       = done_q;
  assign bus_if.mem_req    = mem_req_q;
  assign bus_if.mem_we     = mem_we_q;
  assign bus_if.mem_addr   = cur_addr_q;
  assign bus_if.rf_sel     = idx_q;
  assign bus_if.rf_wen     = mem_req_q & ~mem_we_q & bus_if.mem_ready;
  assign bus_if.xfer_count = xfer_count_q;

endmodule

// File: doc/lmsm_sequencer.md
LMSM_SEQUENCER -- requirements
Module: lmsm_sequencer

Interface
REQ-001 Parameter: ADDR_W, 16, width of memory address and base address.
REQ-002 Parameter: NREG, 8, number of architectural registers covered by the mask; the register index width is 3 for the default.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  request to begin one load-multiple/store-multiple operation.
REQ-006 Port: is_store  input  1  1 = store-multiple (RF to memory), 0 = load-multiple (memory to RF).
REQ-007 Port: base_addr  input  ADDR_W  first memory address.
REQ-008 Port: reg_mask  input  NREG  bit i set means register i is transferred.
REQ-009 Port: mem_ready  input  1  memory completes the current access in this cycle.
REQ-010 Port: busy  output  1  operation in progress (state not IDLE).
REQ-011 Port: done  output  1  one-cycle completion pulse.
REQ-012 Port: mem_req  output  1  memory access request.
REQ-013 Port: mem_we  output  1  store access; valid only while mem_req=1.
REQ-014 Port: mem_addr  output  ADDR_W  address of the current access.
REQ-015 Port: rf_sel  output  3  register index being read (store) or written (load).
REQ-016 Port: rf_wen  output  1  register-file write enable for load data.
REQ-017 Port: xfer_count  output  4  number of registers transferred by the last or current operation.

Function
REQ-018 The FSM SHALL have exactly the states IDLE, SCAN, ACCESS and DONE, encoded in 2 bits.
REQ-019 IDLE: on start=1, the block SHALL latch is_store, base_addr into cur_addr and reg_mask into rem_mask, clear xfer_count and go to SCAN; otherwise it stays in IDLE.
REQ-020 start SHALL be ignored in every state other than IDLE.
REQ-021 SCAN: if rem_mask=0, go to DONE; otherwise load idx with the lowest set bit of rem_mask and go to ACCESS.
REQ-022 ACCESS: mem_req=1, mem_we=latched is_store, mem_addr=cur_addr and rf_sel=idx, all held stable until mem_ready=1.
REQ-023 ACCESS with mem_ready=1 on a load: rf_wen=1 combinationally in that same cycle. rf_wen is 0 at all other times and always 0 for stores.
REQ-024 ACCESS with mem_ready=1: clear rem_mask[idx], set cur_addr=cur_addr+1 (modulo 2^ADDR_W, 0xFFFF wraps to 0x0000), increment xfer_count, and go to SCAN.
REQ-025 ACCESS with mem_ready=0: no state change (wait state, unbounded).
REQ-026 DONE: done=1 for exactly one cycle, then go to IDLE. xfer_count SHALL hold its value until the next accepted start.
REQ-027 Register i SHALL always map to base_addr plus the number of set mask bits below i, with transfers in ascending index order.
REQ-028 Latency with mem_ready tied to 1: done is asserted 2 + 2*popcount(reg_mask) cycles after the start edge.
REQ-029 mem_ready outside ACCESS SHALL be ignored.
REQ-030 mem_req, mem_we and rf_wen SHALL be 0 in IDLE, SCAN and DONE.

Reset
REQ-031 On rst_n=0, the block SHALL asynchronously force state=IDLE, rem_mask=0, cur_addr=0, idx=0 and xfer_count=0.
REQ-032 While rst_n=0, all outputs SHALL be 0: busy, done, mem_req, mem_we, mem_addr, rf_sel, rf_wen and xfer_count.
REQ-033 Reset during ACCESS SHALL drop mem_req and rf_wen immediately, without waiting for a clock edge. No done pulse is produced, and the operation is abandoned.
REQ-034 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-035 Load, mask=0x05, base=0x0040, mem_ready=1 -> ACCESS at 0x0040 with rf_sel=0 and rf_wen=1; then 0x0041 with rf_sel=2; done at cycle 6; xfer_count=2.
REQ-036 Store, mask=0x80, base=0x1000, mem_ready low for 3 ACCESS cycles -> mem_req, mem_we=1, addr=0x1000 and rf_sel=7 held stable for 4 cycles; rf_wen=0 throughout; done follows; xfer_count=1.
REQ-037 mask=0x00 -> no mem_req ever; done at cycle 2 after start; xfer_count=0.
REQ-038 Load, mask=0xFF, base=0xFFFE -> addresses 0xFFFE, 0xFFFF, 0x0000 ... 0x0005; rf_sel 0..7; xfer_count=8; done at cycle 18.
REQ-039 start pulsed while busy -> ignored; the in-flight sequence and xfer_count are unaffected.
REQ-040 rst_n low mid-ACCESS between clock edges -> mem_req=0 immediately; busy=0; no done; a new start is accepted normally after release.
